// File: rtl/switch_debouncer_pkg.sv
// Board-level constants and helpers shared by the switch debouncer files.
`timescale 1ns/1ps
package switch_debouncer_pkg;

  localparam int CLK_HZ               = 100_000_000;
  localparam int DEFAULT_TICK_DIV     = CLK_HZ / 1000;
  localparam int DEFAULT_STABLE_TICKS = 10;
  localparam int DEFAULT_N_CH         = 5;

  // Counter width that stays at least one bit for degenerate parameter values.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_debouncer_debounce_channel.sv
// One debounce channel: 2-FF synchroniser, stability counter, debounced level and edge strobes.
`timescale 1ns/1ps
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_sw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);

  localparam int                CW     = clog2_min1(STABLE_TICKS);
  localparam logic [CW-1:0]     C_LAST = CW'(STABLE_TICKS - 1);

  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  logic          r_db;
  logic          r_rise;
  logic          r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_sw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      // Any sample matching the accepted level throws away the pending candidate.
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == C_LAST) begin
          r_db   <= r_s2;
          r_cnt  <= '0;
          r_rise <= r_s2;
          r_fall <= ~r_s2;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: one shared sample-tick prescaler feeding N_CH independent channels.
`timescale 1ns/1ps
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int N_CH         = DEFAULT_N_CH,
  parameter int TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_db,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic            tick
);

  localparam int            PW     = clog2_min1(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          w_presc_wrap;

  assign w_presc_wrap = (r_presc == P_LAST);

  // Tick is registered, so it is high in the cycle after the prescaler hits its last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= w_presc_wrap;
      r_presc <= w_presc_wrap ? '0 : r_presc + PW'(1);
    end
  end

  assign tick = r_tick;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_tick (r_tick),
      .i_sw   (sw_in[g]),
      .o_db   (sw_db[g]),
      .o_rise (sw_rise[g]),
      .o_fall (sw_fall[g])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with TICK_DIV=4, STABLE_TICKS=3.
`timescale 1ns/1ps
module tb_switch_debouncer;

  localparam int N_CH         = 5;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] sw_in;
  logic [N_CH-1:0] sw_db;
  logic [N_CH-1:0] sw_rise;
  logic [N_CH-1:0] sw_fall;
  logic            tick;

  int n_vec = 0;
  int n_err = 0;

  int rise_cnt [N_CH] = '{default: 0};
  int fall_cnt [N_CH] = '{default: 0};
  int both_viol  = 0;
  int tick_viol  = 0;
  int tick_total = 0;
  int tick_gap   = 0;
  bit tick_seen  = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  switch_debouncer #(
    .N_CH        (N_CH),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .sw_db  (sw_db),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .tick   (tick)
  );

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      tick_seen = 1'b0;
      tick_gap  = 0;
    end else begin
      tick_gap = tick_gap + 1;
      if (tick) begin
        if (tick_seen && tick_gap != TICK_DIV) tick_viol = tick_viol + 1;
        tick_gap   = 0;
        tick_seen  = 1'b1;
        tick_total = tick_total + 1;
      end else if (tick_seen && tick_gap > TICK_DIV) begin
        tick_viol = tick_viol + 1;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (sw_rise[i]) rise_cnt[i] = rise_cnt[i] + 1;
        if (sw_fall[i]) fall_cnt[i] = fall_cnt[i] + 1;
        if (sw_rise[i] && sw_fall[i]) both_viol = both_viol + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_db(input int ch, input logic val, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat = lat + 1;
    end while (sw_db[ch] !== val && lat < 40);
  endtask

  task automatic wait_all(input logic [N_CH-1:0] val, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat = lat + 1;
    end while (sw_db !== val && lat < 40);
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    int   lat;
    int   r_snap;
    int   f_snap;
    logic moved;

    rst_n = 1'b0;
    sw_in = '1;
    step(3);
    chk("rst_db",   32'(sw_db),   32'h0);
    chk("rst_rise", 32'(sw_rise), 32'h0);
    chk("rst_fall", 32'(sw_fall), 32'h0);
    chk("rst_tick", 32'(tick),    32'h0);

    // Release with all switches high: prescaler from 0, first tick after edge 4, commit at edge 13.
    rst_n = 1'b1;
    wait_all(5'b11111, lat);
    chk("s1_lat", lat, 13);
    chk("s1_rise_all", 32'(sw_rise), 32'h1f);
    chk("s1_fall_none", 32'(sw_fall), 32'h0);
    step(1);
    chk("s1_rise_one_cycle", 32'(sw_rise), 32'h0);
    step(5);
    for (int i = 0; i < N_CH; i++) chk($sformatf("s1_rise_cnt_ch%0d", i), rise_cnt[i], 1);

    // Bring everything low for the per-channel scenarios.
    sw_in = '0;
    wait_all(5'b00000, lat);
    chk($sformatf("clr_lat=%0d in 11..14", lat), 32'(lat >= 11 && lat <= 14), 1);
    chk("clr_fall_all", 32'(sw_fall), 32'h1f);
    step(5);

    // Clean rising edge on ch0.
    r_snap = rise_cnt[0];
    f_snap = fall_cnt[0];
    step(1);
    sw_in[0] = 1'b1;
    wait_db(0, 1'b1, lat);
    chk($sformatf("s2_lat=%0d in 11..14", lat), 32'(lat >= 11 && lat <= 14), 1);
    chk("s2_db0", 32'(sw_db[0]), 1);
    chk("s2_rise_at_commit", 32'(sw_rise[0]), 1);
    step(1);
    chk("s2_rise_pulse_end", 32'(sw_rise[0]), 0);
    step(5);
    chk("s2_rise_count", rise_cnt[0] - r_snap, 1);
    chk("s2_fall_count", fall_cnt[0] - f_snap, 0);

    // Bounce on ch1: 14 toggles every 3 cycles, ending low, then a clean rise.
    r_snap = rise_cnt[1];
    moved  = 1'b0;
    for (int t = 0; t < 14; t++) begin
      sw_in[1] = ~sw_in[1];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (sw_db[1]) moved = 1'b1;
      end
    end
    chk("s3_bounce_db_steady", 32'(moved), 0);
    chk("s3_bounce_no_rise", rise_cnt[1] - r_snap, 0);
    sw_in[1] = 1'b1;
    wait_db(1, 1'b1, lat);
    chk($sformatf("s3_lat=%0d in 11..14", lat), 32'(lat >= 11 && lat <= 14), 1);
    chk("s3_rise_at_commit", 32'(sw_rise[1]), 1);
    step(5);
    chk("s3_rise_count", rise_cnt[1] - r_snap, 1);

    // Release ch0.
    r_snap = rise_cnt[0];
    f_snap = fall_cnt[0];
    sw_in[0] = 1'b0;
    wait_db(0, 1'b0, lat);
    chk($sformatf("s4_lat=%0d in 11..14", lat), 32'(lat >= 11 && lat <= 14), 1);
    chk("s4_fall_at_commit", 32'(sw_fall[0]), 1);
    chk("s4_rise_at_commit", 32'(sw_rise[0]), 0);
    step(5);
    chk("s4_fall_count", fall_cnt[0] - f_snap, 1);
    chk("s4_rise_count", rise_cnt[0] - r_snap, 0);

    // Pre-settle ch4 high, then ch2 up and ch4 down together.
    sw_in[4] = 1'b1;
    wait_db(4, 1'b1, lat);
    chk($sformatf("s5_pre_lat=%0d in 11..14", lat), 32'(lat >= 11 && lat <= 14), 1);
    step(5);
    sw_in[2] = 1'b1;
    sw_in[4] = 1'b0;
    wait_db(2, 1'b1, lat);
    chk($sformatf("s5_lat=%0d in 11..14", lat), 32'(lat >= 11 && lat <= 14), 1);
    chk("s5_db4_low", 32'(sw_db[4]), 0);
    chk("s5_strobes", 32'(sw_rise | sw_fall), 32'h14);
    chk("s5_rise2", 32'(sw_rise[2]), 1);
    chk("s5_fall4", 32'(sw_fall[4]), 1);
    chk("s5_others", 32'(sw_db & 5'b01011), 32'h02);
    step(5);
    chk("s5_db_final", 32'(sw_db), 32'h06);

    // Async reset in the middle of a ch3 count.
    sw_in[3] = 1'b1;
    step(7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_async_db",   32'(sw_db),   32'h0);
    chk("s6_async_rise", 32'(sw_rise), 32'h0);
    chk("s6_async_fall", 32'(sw_fall), 32'h0);
    chk("s6_async_tick", 32'(tick),    32'h0);
    step(2);
    rst_n = 1'b1;
    wait_all(5'b01110, lat);
    chk("s6_lat_after_release", lat, 13);
    chk("s6_rise_at_commit", 32'(sw_rise), 32'h0e);
    step(5);

    chk("tick_period_viol", tick_viol, 0);
    chk("rise_fall_both_high", both_viol, 0);
    chk("tick_ever_seen", 32'(tick_total > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
